// File: rtl/prci_rst_gen.sv
// Reset-request generator feeding the PRCI: debounced button, watchdog and DMI requests
// become minimum-width power-on / debug reset pulses, with the last reset cause kept for readback.
module prci_rst_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POR_CYCLES      = 64,
    parameter int DMI_CYCLES      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    input  logic       i_wdog_expired,
    input  logic       i_dmi_rst_req,
    output logic       o_pwrreset,
    output logic       o_dmireset,
    output logic [3:0] o_rst_cause,
    output logic       o_busy
);

    localparam int MAX_PD = (POR_CYCLES > DMI_CYCLES) ? POR_CYCLES : DMI_CYCLES;
    localparam int MAX_C  = (MAX_PD > DEBOUNCE_CYCLES) ? MAX_PD : DEBOUNCE_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] POR_LAST = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] DMI_LAST = CW'(DMI_CYCLES - 1);

    localparam logic [3:0] CAUSE_POR  = 4'b0001;
    localparam logic [3:0] CAUSE_BTN  = 4'b0010;
    localparam logic [3:0] CAUSE_WDOG = 4'b0100;
    localparam logic [3:0] CAUSE_DMI  = 4'b1000;

    typedef enum logic [1:0] {
        ST_POR      = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PWR_HOLD = 2'd2,
        ST_DMI_HOLD = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_count_inc;
    logic [3:0]    r_cause;
    logic [3:0]    w_cause_nxt;
    logic          r_pwrreset;
    logic          r_dmireset;
    logic          r_busy;

    logic          r_btn_s1;
    logic          r_btn_s2;
    logic          r_btn_db;
    logic [CW-1:0] r_db_cnt;
    logic          r_dmi_req_d;
    logic          w_dmi_edge;

    // Button path: 2-flop synchroniser, then accept a new level only after it has been stable long enough.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_s1    <= 1'b0;
            r_btn_s2    <= 1'b0;
            r_btn_db    <= 1'b0;
            r_db_cnt    <= '0;
            r_dmi_req_d <= 1'b0;
        end else begin
            r_btn_s1    <= i_btn;
            r_btn_s2    <= r_btn_s1;
            r_dmi_req_d <= i_dmi_rst_req;
            if (r_btn_s2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= r_btn_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + CW'(1);
            end
        end
    end

    assign w_dmi_edge  = i_dmi_rst_req & ~r_dmi_req_d;
    assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_cause_nxt = r_cause;
        case (r_state)
            ST_POR: begin
                if (r_count == POR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end
            ST_IDLE: begin
                w_count_nxt = '0;
                if (r_btn_db) begin
                    w_state_nxt = ST_PWR_HOLD;
                    w_cause_nxt = CAUSE_BTN;
                end else if (i_wdog_expired) begin
                    w_state_nxt = ST_PWR_HOLD;
                    w_cause_nxt = CAUSE_WDOG;
                end else if (w_dmi_edge) begin
                    w_state_nxt = ST_DMI_HOLD;
                    w_cause_nxt = CAUSE_DMI;
                end
            end
            ST_PWR_HOLD: begin
                // A held button stretches the pulse; the hold window starts at release.
                if (r_btn_db) begin
                    w_count_nxt = '0;
                end else if (r_count == POR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end
            ST_DMI_HOLD: begin
                if (r_btn_db) begin
                    w_state_nxt = ST_PWR_HOLD;
                    w_count_nxt = '0;
                    w_cause_nxt = CAUSE_BTN;
                end else if (i_wdog_expired) begin
                    w_state_nxt = ST_PWR_HOLD;
                    w_count_nxt = '0;
                    w_cause_nxt = CAUSE_WDOG;
                end else if (r_count == DMI_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end
            default: begin
                w_state_nxt = ST_POR;
                w_count_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the edge that changes state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_POR;
            r_count    <= '0;
            r_cause    <= CAUSE_POR;
            r_pwrreset <= 1'b1;
            r_dmireset <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_cause    <= w_cause_nxt;
            r_pwrreset <= (w_state_nxt == ST_POR) || (w_state_nxt == ST_PWR_HOLD);
            r_dmireset <= (w_state_nxt == ST_DMI_HOLD);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_pwrreset  = r_pwrreset;
    assign o_dmireset  = r_dmireset;
    assign o_rst_cause = r_cause;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_prci_rst_gen.sv
// Bench for prci_rst_gen: expected reset pulses are queued as stimulus is applied and
// compared against pulses captured from the outputs.
module tb_prci_rst_gen;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_btn = 1'b0;
    logic       i_wdog_expired = 1'b0;
    logic       i_dmi_rst_req = 1'b0;
    logic       o_pwrreset;
    logic       o_dmireset;
    logic [3:0] o_rst_cause;
    logic       o_busy;

    typedef struct packed {
        logic       kind;   // 0 = pwrreset, 1 = dmireset
        int         rise;
        int         fall;
        logic [3:0] cause;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic both_seen = 1'b0;
    logic prev_p = 1'b0;
    logic prev_d = 1'b0;
    int   p_rise = 0;
    int   d_rise = 0;
    logic [3:0] p_cause = 4'b0;
    logic [3:0] d_cause = 4'b0;

    prci_rst_gen dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_btn          (i_btn),
        .i_wdog_expired (i_wdog_expired),
        .i_dmi_rst_req  (i_dmi_rst_req),
        .o_pwrreset     (o_pwrreset),
        .o_dmireset     (o_dmireset),
        .o_rst_cause    (o_rst_cause),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse capture: rise/fall are the edge numbers on which the output changed.
    always @(negedge clk) begin
        if (o_pwrreset && o_dmireset) both_seen = 1'b1;
        if (o_pwrreset && !prev_p) begin p_rise = cyc; p_cause = o_rst_cause; end
        if (!o_pwrreset && prev_p) obs_q.push_back('{1'b0, p_rise, cyc, p_cause});
        if (o_dmireset && !prev_d) begin d_rise = cyc; d_cause = o_rst_cause; end
        if (!o_dmireset && prev_d) obs_q.push_back('{1'b1, d_rise, cyc, d_cause});
        prev_p = o_pwrreset;
        prev_d = o_dmireset;
    end

    task automatic test_reset();
        int r;
        int w;
        repeat (3) @(negedge clk);
        tests++; if (o_pwrreset !== 1'b1) begin fails++; $display("FAIL reset_pwr got=%b exp=1", o_pwrreset); end
        tests++; if (o_dmireset !== 1'b0) begin fails++; $display("FAIL reset_dmi got=%b exp=0", o_dmireset); end
        tests++; if (o_rst_cause !== 4'b0001) begin fails++; $display("FAIL reset_cause got=%b exp=0001", o_rst_cause); end
        tests++; if (o_busy !== 1'b1) begin fails++; $display("FAIL reset_busy got=%b exp=1", o_busy); end
        r = cyc;
        i_rst = 1'b0;
        for (int i = 0; i < 200 && o_pwrreset === 1'b1; i++) @(negedge clk);
        w = cyc - r;
        tests++; if (w !== 64) begin fails++; $display("FAIL por_width got=%0d exp=64", w); end
        tests++; if (o_rst_cause !== 4'b0001) begin fails++; $display("FAIL por_cause got=%b exp=0001", o_rst_cause); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL por_busy_after got=%b exp=0", o_busy); end
        repeat (3) @(negedge clk);
        obs_q.delete();
    endtask

    task automatic test_btn_bounce();
        for (int i = 0; i < 40; i++) begin
            i_btn = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        i_btn = 1'b0;
        repeat (40) @(negedge clk);
        tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL bounce_pulses got=%0d exp=0", obs_q.size()); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL bounce_busy got=%b exp=0", o_busy); end
        obs_q.delete();
    endtask

    task automatic test_btn_hold();
        int k;
        pulse_t e;
        pulse_t o;
        k = cyc;
        i_btn = 1'b1;
        exp_q.push_back('{1'b0, k + 19, k + 182, 4'b0010});
        repeat (100) @(negedge clk);
        i_btn = 1'b0;
        repeat (100) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL btn_hold_pulse got=none exp rise=%0d fall=%0d", e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL btn_hold_pulse got k=%0d r=%0d f=%0d c=%b exp k=%0d r=%0d f=%0d c=%b",
                             o.kind, o.rise, o.fall, o.cause, e.kind, e.rise, e.fall, e.cause);
                end
            end
        end
        tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL btn_hold_extra got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_dmi_level();
        int k;
        pulse_t e;
        pulse_t o;
        k = cyc;
        i_dmi_rst_req = 1'b1;
        exp_q.push_back('{1'b1, k + 1, k + 9, 4'b1000});
        repeat (50) @(negedge clk);
        i_dmi_rst_req = 1'b0;
        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL dmi_level_pulse got=none exp rise=%0d fall=%0d", e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL dmi_level_pulse got k=%0d r=%0d f=%0d c=%b exp k=%0d r=%0d f=%0d c=%b",
                             o.kind, o.rise, o.fall, o.cause, e.kind, e.rise, e.fall, e.cause);
                end
            end
        end
        tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL dmi_level_extra got=%0d exp=0", obs_q.size()); end
        tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL dmi_level_exclusive got=%b exp=0", both_seen); end
        obs_q.delete();
    endtask

    task automatic test_dmi_preempt();
        int k;
        pulse_t e;
        pulse_t o;
        k = cyc;
        i_dmi_rst_req = 1'b1;
        exp_q.push_back('{1'b1, k + 1, k + 4, 4'b1000});
        exp_q.push_back('{1'b0, k + 4, k + 68, 4'b0100});
        @(negedge clk);
        i_dmi_rst_req = 1'b0;
        repeat (2) @(negedge clk);
        i_wdog_expired = 1'b1;
        @(negedge clk);
        i_wdog_expired = 1'b0;
        repeat (75) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL preempt_pulse got=none exp kind=%0d rise=%0d", e.kind, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL preempt_pulse got k=%0d r=%0d f=%0d c=%b exp k=%0d r=%0d f=%0d c=%b",
                             o.kind, o.rise, o.fall, o.cause, e.kind, e.rise, e.fall, e.cause);
                end
            end
        end
        tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL preempt_extra got=%0d exp=0", obs_q.size()); end
        tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL preempt_exclusive got=%b exp=0", both_seen); end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int k;
        pulse_t e;
        pulse_t o;
        // Watchdog and DMI edge together: watchdog wins, DMI request is consumed.
        k = cyc;
        i_wdog_expired = 1'b1;
        i_dmi_rst_req  = 1'b1;
        exp_q.push_back('{1'b0, k + 1, k + 65, 4'b0100});
        @(negedge clk);
        i_wdog_expired = 1'b0;
        repeat (9) @(negedge clk);
        i_dmi_rst_req = 1'b0;
        repeat (70) @(negedge clk);
        // i_rst inside PWR_HOLD restarts a full POR window.
        k = cyc;
        i_wdog_expired = 1'b1;
        exp_q.push_back('{1'b0, k + 1, k + 86, 4'b0100});
        @(negedge clk);
        i_wdog_expired = 1'b0;
        repeat (19) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        tests++; if (o_rst_cause !== 4'b0001) begin fails++; $display("FAIL midrst_cause got=%b exp=0001", o_rst_cause); end
        tests++; if (o_pwrreset !== 1'b1) begin fails++; $display("FAIL midrst_pwr got=%b exp=1", o_pwrreset); end
        @(negedge clk);
        i_rst = 1'b0;
        repeat (80) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL b2b_pulse got=none exp rise=%0d fall=%0d", e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL b2b_pulse got k=%0d r=%0d f=%0d c=%b exp k=%0d r=%0d f=%0d c=%b",
                             o.kind, o.rise, o.fall, o.cause, e.kind, e.rise, e.fall, e.cause);
                end
            end
        end
        tests++; if (obs_q.size() !== 0) begin fails++; $display("FAIL b2b_extra got=%0d exp=0", obs_q.size()); end
        tests++; if (o_rst_cause !== 4'b0001) begin fails++; $display("FAIL b2b_final_cause got=%b exp=0001", o_rst_cause); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL b2b_final_busy got=%b exp=0", o_busy); end
        tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL b2b_exclusive got=%b exp=0", both_seen); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_btn_bounce();
        test_btn_hold();
        test_dmi_level();
        test_dmi_preempt();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
